// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the fetch-stage program counter.
// Imported by the top block and by the redirect buffer.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic        CHIP_ENABLE          = 1'b1;
    localparam logic        CHIP_DISABLE         = 1'b0;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_buf.sv
// Redirect selection for the fetch PC: aligns flush/branch targets, buffers a
// branch that could not be taken yet, and flags targets with low bits set.
module pc_redirect_buf
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_target,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  accept,
    output logic                  redirect_take,
    output logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  misaligned_fault
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;

    function automatic logic [ADDR_WIDTH-1:0] align_target(input logic [ADDR_WIDTH-1:0] target);
        return target & ALIGN_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] target);
        return |(target & ~ALIGN_MASK);
    endfunction

    logic                  pending_valid;
    logic [ADDR_WIDTH-1:0] pending_target;
    logic                  capture_new;
    logic [ADDR_WIDTH-1:0] capture_target;

    // A fresh flush or branch always outranks the buffered target.
    always_comb begin
        capture_new     = flush | branch_valid;
        capture_target  = flush ? flush_target : branch_target;
        redirect_take   = flush | ((branch_valid | pending_valid) & accept);
        redirect_target = capture_new ? align_target(capture_target) : pending_target;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_valid    <= 1'b0;
            misaligned_fault <= 1'b0;
        end else begin
            misaligned_fault <= capture_new & is_misaligned(capture_target);
            if (redirect_take) begin
                pending_valid <= 1'b0;
            end else if (branch_valid) begin
                pending_valid <= 1'b1;
            end
        end
    end

    // Target storage carries no reset; pending_valid alone qualifies it.
    always_ff @(posedge clock) begin
        if (!redirect_take && branch_valid) begin
            pending_target <= redirect_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: IDLE/RUN/HALT control plus next-PC selection.
// The address only advances once instruction memory accepts it.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            INSTR_BYTES  = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int unsigned            ALIGN_BITS   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  halt,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_target,
    input  logic                  fetch_ready,
    output logic [ADDR_WIDTH-1:0] program_counter,
    output logic                  chip_enable,
    output logic                  misaligned_fault
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSTR_BYTES);

    fetch_state_t          state;
    logic                  accept;
    logic                  redirect_take;
    logic [ADDR_WIDTH-1:0] redirect_target;

    assign accept = (state == ST_RUN) && (chip_enable == CHIP_ENABLE) && fetch_ready && !stall;

    pc_redirect_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ALIGN_BITS (ALIGN_BITS)
    ) redirect_buf (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .flush_target     (flush_target),
        .branch_valid     (branch_valid),
        .branch_target    (branch_target),
        .accept           (accept),
        .redirect_take    (redirect_take),
        .redirect_target  (redirect_target),
        .misaligned_fault (misaligned_fault)
    );

    // The accepted address may still advance on the cycle halt is first seen;
    // holding starts once the state is HALT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            program_counter <= RESET_VECTOR;
            chip_enable     <= CHIP_DISABLE;
        end else begin
            if (redirect_take) begin
                program_counter <= redirect_target;
            end else if (accept) begin
                program_counter <= program_counter + PC_STEP;
            end

            if (flush) begin
                state       <= ST_RUN;
                chip_enable <= CHIP_ENABLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state       <= ST_RUN;
                        chip_enable <= CHIP_ENABLE;
                    end
                    ST_RUN: begin
                        if (halt) begin
                            state       <= ST_HALT;
                            chip_enable <= CHIP_DISABLE;
                        end else begin
                            chip_enable <= CHIP_ENABLE;
                        end
                    end
                    ST_HALT: begin
                        if (!halt) begin
                            state       <= ST_RUN;
                            chip_enable <= CHIP_ENABLE;
                        end else begin
                            chip_enable <= CHIP_DISABLE;
                        end
                    end
                    default: begin
                        state       <= ST_IDLE;
                        chip_enable <= CHIP_DISABLE;
                    end
                endcase
            end
        end
    end

endmodule
